regfile: RTL
============

// Module: regfile
// PURPOSE
//  Architectural register file, 32 entries, two read ports, one write port.
//  Sits directly downstream of the 5:32 write-address decoder: the decoder's
//  one-hot output, gated by RegWrite, selects which entry latches WriteData.
//  Read ports feed operand A/B of the ALU stage. Register 31 is the zero
//  register (XZR): it is never written and always reads 0.
// PARAMETERS
//  DATA_WIDTH  64  width of each register and of the data ports
//  NUM_REGS    32  entry count; fixed by the 5-bit address and the 5:32 decoder
//  BYPASS      0   1 = a read of the entry being written returns WriteData in
//                  the same cycle (write-through); 0 = the read returns the old value
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           asynchronous, active-high; clears all entries
//  RegWrite       in   1           write enable; drives the decoder enable
//  WriteRegister  in   5           write address (decoder data_in)
//  WriteData      in   DATA_WIDTH  value to write
//  ReadRegister1  in   5           read address, port 1
//  ReadRegister2  in   5           read address, port 2
//  ReadData1      out  DATA_WIDTH  contents of ReadRegister1
//  ReadData2      out  DATA_WIDTH  contents of ReadRegister2
// BEHAVIOUR
//  - Storage: 31 DATA_WIDTH-bit registers (X0..X30) built from D flip-flops
//    with async clear. X31 has no storage; it is a constant 0.
//  - Reset: on reset=1, all X0..X30 clear to 0 immediately, without waiting
//    for a clock edge. ReadData1/2 are therefore 0 while reset is held.
//    Writes are ignored while reset=1. Reset asserted mid-write wins: the
//    entry ends at 0.
//  - Write: instantiate decoder(enable=RegWrite, data_in=WriteRegister).
//    On posedge clk, entry i loads WriteData iff data_out[i]=1 and i!=31.
//    Otherwise the entry holds its value (per-bit feedback mux, no clock
//    gating). Exactly 0 or 1 entries change per cycle.
//    Write latency: 1 cycle. The new value is visible on the read ports
//    after the edge.
//  - Write to X31: decoded but discarded. No state changes.
//  - Read: combinational, 0 cycles. ReadDataN = X[ReadRegisterN] through a
//    32:1 mux per bit, for example a tree of 4:1 muxes.
//    ReadRegisterN=31 -> ReadDataN = 0.
//  - Both ports may read the same address, including the write address,
//    in the same cycle.
//  - Read during write, same address, BYPASS=0: ReadData shows the old value
//    until the edge and the new value after it.
//  - Read during write, same address, BYPASS=1, RegWrite=1, address!=31:
//    ReadData = WriteData combinationally.
//  - Decoder gate delays (#50 per level) mean write enables settle about
//    200 ns after the address changes. The minimum clock period must cover
//    decoder settle + mux + setup time; the bench uses a 1000 ns period or
//    longer.
//  - X/Z on WriteRegister while RegWrite=0 must not corrupt any entry.
// TESTING
//  1 Reset: write X0..X30 = i*0x0101, then pulse reset between edges ->
//    all reads return 0 before the next posedge.
//  2 Write/read all: for i=0..30 write 0xA5A5_0000_0000_0000+i, then read
//    every i on both ports -> the exact value; reading 31 -> 0.
//  3 X31 write: RegWrite=1, WriteRegister=31, WriteData=all-ones -> reading
//    31 returns 0, and X0..X30 are unchanged.
//  4 RegWrite=0: WriteRegister=5, WriteData=0xDEAD, clock 3 edges -> X5
//    keeps its prior value.
//  5 Same-cycle read/write of X7 (old value 0x11, new value 0x22):
//    BYPASS=0 -> 0x11 before the edge, 0x22 after it;
//    BYPASS=1 -> 0x22 before the edge.
//  6 Dual port: ReadRegister1=3, ReadRegister2=30 with distinct data ->
//    each port returns its own entry; no cross-talk under random addresses.

Source files
------------

// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if: bus bundle between the pipeline and the architectural register
// file. The register file consumes the write request and the two read
// addresses, and returns the two read operands.
//
// Signals
//   RegWrite       master->slave  write enable (decoder enable)
//   WriteRegister  master->slave  5-bit write address
//   WriteData      master->slave  value to write
//   ReadRegister1  master->slave  read address, port 1
//   ReadRegister2  master->slave  read address, port 2
//   ReadData1      slave->master  contents of ReadRegister1
//   ReadData2      slave->master  contents of ReadRegister2
//
// Transfer semantics: there is no valid/ready pair. A write is taken on every
// rising clock edge where RegWrite=1; the slave can never stall it. Reads are
// purely combinational, so an address presented now gives data now.
// ---------------------------------------------------------------------------
interface regfile_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  RegWrite;
  logic [4:0]            WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [4:0]            ReadRegister1;
  logic [4:0]            ReadRegister2;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile: 32-entry architectural register file, two combinational read ports
// and one synchronous write port. Entry 31 is the zero register (XZR): it has
// no storage, writes to it are dropped and it always reads 0.
//
// Also contains the 5:32 write-address decoder it is built around.
//
// Ports
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high; clears X0..X30 immediately
//   bus    slave side of regfile_if (write request, read addresses/data)
//
// Parameters
//   DATA_WIDTH  width of each entry and of the data ports
//   NUM_REGS    entry count (32, tied to the 5-bit address)
//   BYPASS      1 = a read of the entry being written returns WriteData in the
//               same cycle; 0 = it returns the old value until the edge
// ---------------------------------------------------------------------------

// 5:32 one-hot decoder. With enable low the output is all zeros regardless of
// data_in, so an unknown write address cannot select an entry.
module decoder (
  input  logic        enable,
  input  logic [4:0]  data_in,
  output logic [31:0] data_out
);
  always_comb begin
    data_out = '0;
    if (enable) begin
      data_out[data_in] = 1'b1;
    end
  end
endmodule

module regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int BYPASS     = 0
) (
  input  logic       clk,
  input  logic       reset,
  regfile_if.slave   bus
);
  localparam int ZERO_IDX = NUM_REGS - 1;

  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1];
  logic [DATA_WIDTH-1:0] rd_view [NUM_REGS];
  logic                  byp_en;
  logic [DATA_WIDTH-1:0] rd1_d;
  logic [DATA_WIDTH-1:0] rd2_d;

  decoder u_dec (
    .enable   (bus.RegWrite),
    .data_in  (bus.WriteRegister),
    .data_out (wr_sel)
  );

  // Per-entry feedback mux: an entry reloads itself unless its decoder line
  // is high. The XZR line (wr_sel[ZERO_IDX]) has no entry to drive.
  always_comb begin
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      regs_d[i] = wr_sel[i] ? bus.WriteData : regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read view: stored entries plus a hard zero in the XZR slot, so the read
  // mux covers all 32 addresses without a special case.
  always_comb begin
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      rd_view[i] = regs_q[i];
    end
    rd_view[ZERO_IDX] = '0;
  end

  // Write-through applies only to a real write: not to XZR, and not while
  // reset holds the array (and the read ports) at zero.
  assign byp_en = (BYPASS != 0) && bus.RegWrite && !reset && !wr_sel[ZERO_IDX];

  always_comb begin
    rd1_d = rd_view[bus.ReadRegister1];
    rd2_d = rd_view[bus.ReadRegister2];
    if (byp_en && (bus.ReadRegister1 == bus.WriteRegister)) begin
      rd1_d = bus.WriteData;
    end
    if (byp_en && (bus.ReadRegister2 == bus.WriteRegister)) begin
      rd2_d = bus.WriteData;
    end
  end

  assign bus.ReadData1 = rd1_d;
  assign bus.ReadData2 = rd2_d;
endmodule
